uart_regmap_master: RTL and testbench

//  Host-side initiator for the UART byte-regmap protocol; the counterpart of uart_byte_regmap_interface.

---
 rtl/uart_regmap_pkg.sv | 29 ++
 rtl/uart_regmap_master_if.sv | 32 +++
 rtl/uart_regmap_timer.sv | 34 +++
 rtl/uart_regmap_master.sv | 246 ++++++++++++++++++++++++
 tb/tb_uart_regmap_master.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_regmap_pkg.sv
// Shared types and helpers for the UART byte-regmap host initiator.
//   state_e      : initiator FSM states
//   HDR_READ_BIT : header bit that marks a read request
//   make_hdr()   : builds the request header {rd, slave_id}
package uart_regmap_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND_HDR,
        ST_SEND_ADDR,
        ST_SEND_WDATA,
        ST_SEND_LEN,
        ST_TX_WAIT,
        ST_GAP,
        ST_RX_HDR,
        ST_RX_DATA,
        ST_DONE
    } state_e;

    localparam int HDR_READ_BIT = 7;

    function automatic logic [7:0] make_hdr(input logic rd, input logic [6:0] id);
        logic [7:0] h;
        h               = {1'b0, id};
        h[HDR_READ_BIT] = rd;
        return h;
    endfunction

endpackage

// File: rtl/uart_regmap_master_if.sv
// Controller-side command/data interface of the regmap initiator.
//   master modport : local controller (issues commands, supplies write data)
//   slave modport  : uart_regmap_master (consumes commands, returns read data/status)
interface uart_regmap_master_if #(
    parameter int NUM_ADDR_BYTES = 2
) ();
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic                        cmd_read;
    logic [6:0]                  cmd_slave_id;
    logic [NUM_ADDR_BYTES*8-1:0] cmd_address;
    logic [7:0]                  cmd_len_m1;
    logic [7:0]                  wr_data;
    logic                        wr_data_valid;
    logic                        wr_data_ready;
    logic [7:0]                  rd_data;
    logic                        rd_data_valid;
    logic                        done;
    logic                        error;

    modport master (
        output cmd_valid, cmd_read, cmd_slave_id, cmd_address, cmd_len_m1,
               wr_data, wr_data_valid,
        input  cmd_ready, wr_data_ready, rd_data, rd_data_valid, done, error
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_slave_id, cmd_address, cmd_len_m1,
               wr_data, wr_data_valid,
        output cmd_ready, wr_data_ready, rd_data, rd_data_valid, done, error
    );
endinterface

// File: rtl/uart_regmap_timer.sv
// Loadable down-counter shared by the post-request idle gap and the
// response-byte timeout.
//   clk, rst_n  : clock, async active-low reset
//   load_i      : load load_val_i (wins over dec_i)
//   load_val_i  : value to load
//   dec_i       : decrement by one, saturating at zero
//   zero_o      : counter is zero
module uart_regmap_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/uart_regmap_master.sv
// Host-side initiator for the UART byte-regmap protocol. Takes one command,
// serialises header/address/(data|len) into uart_tx, holds the line idle for
// GAP_CYCLES so the far end can frame the request, then (reads) collects the
// echoed header plus len_m1+1 data bytes from uart_rx.
//   clk, rst_n       : clock, async active-low reset
//   host (slave)     : command, write-data stream, read-data stream, done/error
//   tx_trig/tx_data  : byte launch to uart_tx; tx_bsy is its busy flag
//   rx_data_valid/out: byte strobe and data from uart_rx
module uart_regmap_master
    import uart_regmap_pkg::*;
#(
    parameter int NUM_ADDR_BYTES = 2,
    parameter int GAP_CYCLES     = 480,
    parameter int RESP_TIMEOUT   = 24000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_regmap_master_if.slave   host,
    output logic                  tx_trig,
    output logic [7:0]            tx_data,
    input  logic                  tx_bsy,
    input  logic                  rx_data_valid,
    input  logic [7:0]            rx_data_out
);
    localparam int AW      = NUM_ADDR_BYTES * 8;
    localparam int ACW     = NUM_ADDR_BYTES;
    localparam int TMR_MAX = (GAP_CYCLES > RESP_TIMEOUT) ? GAP_CYCLES : RESP_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [ACW-1:0]   ADDR_LAST = ACW'(NUM_ADDR_BYTES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] RESP_LOAD = TMR_W'(RESP_TIMEOUT - 1);

    state_e          state_q, state_d, ret_q, ret_d;
    logic [7:0]      hdr_q, hdr_d, len_q, len_d;
    logic            rd_q, rd_d;
    logic [AW-1:0]   addr_sr_q, addr_sr_d;
    logic [ACW-1:0]  addr_cnt_q, addr_cnt_d;
    logic [8:0]      byte_cnt_q, byte_cnt_d;
    logic            err_q, err_d, mism_q, mism_d, echo_got_q, echo_got_d;
    logic            tx_trig_q, tx_trig_d, wr_rdy_q, wr_rdy_d, rd_vld_q, rd_vld_d;
    logic [7:0]      tx_data_q, tx_data_d, rd_data_q, rd_data_d;

    logic             tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0] tmr_val;

    uart_regmap_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        hdr_d      = hdr_q;
        len_d      = len_q;
        rd_d       = rd_q;
        addr_sr_d  = addr_sr_q;
        addr_cnt_d = addr_cnt_q;
        byte_cnt_d = byte_cnt_q;
        err_d      = err_q;
        mism_d     = mism_q;
        echo_got_d = echo_got_q;
        tx_data_d  = tx_data_q;
        rd_data_d  = rd_data_q;
        tx_trig_d  = 1'b0;
        wr_rdy_d   = 1'b0;
        rd_vld_d   = 1'b0;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;
        tmr_val    = '0;

        case (state_q)
            ST_IDLE: begin
                if (host.cmd_valid) begin
                    hdr_d      = make_hdr(host.cmd_read, host.cmd_slave_id);
                    rd_d       = host.cmd_read;
                    len_d      = host.cmd_len_m1;
                    addr_sr_d  = host.cmd_address;
                    addr_cnt_d = '0;
                    byte_cnt_d = '0;
                    err_d      = 1'b0;
                    mism_d     = 1'b0;
                    echo_got_d = 1'b0;
                    state_d    = ST_SEND_HDR;
                end
            end
            ST_SEND_HDR: begin
                if (!tx_bsy) begin
                    tx_trig_d = 1'b1;
                    tx_data_d = hdr_q;
                    ret_d     = ST_SEND_ADDR;
                    state_d   = ST_TX_WAIT;
                end
            end
            ST_SEND_ADDR: begin
                // Address goes out MSB first by shifting the latched copy left.
                if (!tx_bsy) begin
                    tx_trig_d  = 1'b1;
                    tx_data_d  = addr_sr_q[AW-1 -: 8];
                    addr_sr_d  = addr_sr_q << 8;
                    addr_cnt_d = addr_cnt_q + ACW'(1);
                    if (addr_cnt_q == ADDR_LAST)
                        ret_d = rd_q ? ST_SEND_LEN : ST_SEND_WDATA;
                    else
                        ret_d = ST_SEND_ADDR;
                    state_d = ST_TX_WAIT;
                end
            end
            ST_SEND_WDATA: begin
                // No data available is a stall, never a timeout.
                if (!tx_bsy && host.wr_data_valid) begin
                    tx_trig_d  = 1'b1;
                    wr_rdy_d   = 1'b1;
                    tx_data_d  = host.wr_data;
                    byte_cnt_d = byte_cnt_q + 9'd1;
                    ret_d      = (byte_cnt_q == {1'b0, len_q}) ? ST_GAP : ST_SEND_WDATA;
                    state_d    = ST_TX_WAIT;
                end
            end
            ST_SEND_LEN: begin
                if (!tx_bsy) begin
                    tx_trig_d = 1'b1;
                    tx_data_d = len_q;
                    ret_d     = ST_GAP;
                    state_d   = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                // The trigger cycle is skipped: uart_tx only raises busy the
                // cycle after it sees tx_trig.
                if (!tx_trig_q && !tx_bsy) begin
                    state_d = ret_q;
                    if (ret_q == ST_GAP) begin
                        tmr_load   = 1'b1;
                        tmr_val    = GAP_LOAD;
                        byte_cnt_d = '0;
                    end
                end
            end
            ST_GAP: begin
                // A quick far end may echo before the gap expires; keep it.
                if (rd_q && rx_data_valid && !echo_got_q) begin
                    echo_got_d = 1'b1;
                    mism_d     = (rx_data_out != hdr_q);
                    err_d      = (rx_data_out != hdr_q);
                end
                if (tmr_zero) begin
                    if (!rd_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = echo_got_d ? ST_RX_DATA : ST_RX_HDR;
                        tmr_load = 1'b1;
                        tmr_val  = RESP_LOAD;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RX_HDR: begin
                if (rx_data_valid) begin
                    mism_d   = (rx_data_out != hdr_q);
                    err_d    = (rx_data_out != hdr_q);
                    state_d  = ST_RX_DATA;
                    tmr_load = 1'b1;
                    tmr_val  = RESP_LOAD;
                end else if (tmr_zero) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RX_DATA: begin
                // After an echo mismatch bytes are still counted to stay
                // aligned with the far end, but not delivered.
                if (rx_data_valid) begin
                    rd_vld_d   = !mism_q;
                    rd_data_d  = rx_data_out;
                    byte_cnt_d = byte_cnt_q + 9'd1;
                    tmr_load   = 1'b1;
                    tmr_val    = RESP_LOAD;
                    if (byte_cnt_q == {1'b0, len_q})
                        state_d = ST_DONE;
                end else if (tmr_zero) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ret_q      <= ST_IDLE;
            hdr_q      <= '0;
            len_q      <= '0;
            rd_q       <= 1'b0;
            addr_sr_q  <= '0;
            addr_cnt_q <= '0;
            byte_cnt_q <= '0;
            err_q      <= 1'b0;
            mism_q     <= 1'b0;
            echo_got_q <= 1'b0;
            tx_trig_q  <= 1'b0;
            tx_data_q  <= '0;
            wr_rdy_q   <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            hdr_q      <= hdr_d;
            len_q      <= len_d;
            rd_q       <= rd_d;
            addr_sr_q  <= addr_sr_d;
            addr_cnt_q <= addr_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            err_q      <= err_d;
            mism_q     <= mism_d;
            echo_got_q <= echo_got_d;
            tx_trig_q  <= tx_trig_d;
            tx_data_q  <= tx_data_d;
            wr_rdy_q   <= wr_rdy_d;
            rd_vld_q   <= rd_vld_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign host.cmd_ready     = (state_q == ST_IDLE);
    assign host.done          = (state_q == ST_DONE);
    assign host.error         = err_q;
    assign host.wr_data_ready = wr_rdy_q;
    assign host.rd_data       = rd_data_q;
    assign host.rd_data_valid = rd_vld_q;
    assign tx_trig            = tx_trig_q;
    assign tx_data            = tx_data_q;
endmodule

// File: tb/tb_uart_regmap_master.sv
// Directed bench for uart_regmap_master: byte-level uart_tx busy model
// (BYTE_T cycles per byte), hand-driven rx responder, per-scenario tasks.
module tb_uart_regmap_master;
    localparam int NAB    = 2;
    localparam int GAP    = 480;
    localparam int RESP   = 24000;
    localparam int BYTE_T = 240;   // 10 bit-times at 24 clk/bit

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_trig, tx_bsy;
    logic [7:0] tx_data;
    logic       rx_data_valid = 1'b0;
    logic [7:0] rx_data_out = 8'h00;

    uart_regmap_master_if #(.NUM_ADDR_BYTES(NAB)) bus ();

    uart_regmap_master #(
        .NUM_ADDR_BYTES (NAB),
        .GAP_CYCLES     (GAP),
        .RESP_TIMEOUT   (RESP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .host          (bus),
        .tx_trig       (tx_trig),
        .tx_data       (tx_data),
        .tx_bsy        (tx_bsy),
        .rx_data_valid (rx_data_valid),
        .rx_data_out   (rx_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx model: busy for BYTE_T cycles starting the cycle after trig.
    int bsy_cnt = 0;
    always @(posedge clk) begin
        if (tx_trig)          bsy_cnt <= BYTE_T;
        else if (bsy_cnt > 0) bsy_cnt <= bsy_cnt - 1;
    end
    assign tx_bsy = (bsy_cnt != 0);

    int errors = 0, checks = 0;
    bq_t tx_log, rd_log;
    int done_cnt = 0, done_cyc = 0, tx_last_cyc = 0, last_rx = 0, viol = 0;
    logic done_err = 1'b0, chk_stable = 1'b0, prev_done = 1'b0;
    logic [7:0] last_tx = 8'h00;

    // Monitor: logs traffic and counts handshake rule breaks.
    always @(negedge clk) begin
        if (!rst_n) chk_stable = 1'b0;
        if (tx_trig && tx_bsy) viol++;
        if (bus.wr_data_ready && !tx_trig) viol++;
        if (tx_bsy && chk_stable && tx_data !== last_tx) viol++;
        if (bus.done && prev_done) viol++;
        prev_done = bus.done;
        if (tx_trig) begin
            tx_log.push_back(tx_data);
            tx_last_cyc = cyc;
            last_tx     = tx_data;
            chk_stable  = 1'b1;
        end
        if (bus.rd_data_valid) rd_log.push_back(bus.rd_data);
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = bus.error;
        end
    end

    function automatic bit q_eq(input bq_t a, input bq_t b);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic issue(input logic rd, input logic [6:0] id,
                         input logic [15:0] addr, input logic [7:0] len);
        for (int i = 0; i < 30000 && !bus.cmd_ready; i++) @(negedge clk);
        bus.cmd_read     = rd;
        bus.cmd_slave_id = id;
        bus.cmd_address  = addr;
        bus.cmd_len_m1   = len;
        bus.cmd_valid    = 1'b1;
        @(negedge clk);
        bus.cmd_valid    = 1'b0;
        #1;
    endtask

    task automatic feed(input logic [7:0] b);
        bus.wr_data       = b;
        bus.wr_data_valid = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus.wr_data_ready) break;
        end
        bus.wr_data_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int lim);
        for (int i = 0; i < lim && done_cnt == d0; i++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 5000 && tx_log.size() < n; i++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic inject(input logic [7:0] b);
        @(negedge clk);
        rx_data_out   = b;
        rx_data_valid = 1'b1;
        last_rx       = cyc;
        @(negedge clk);
        rx_data_valid = 1'b0;
        repeat (BYTE_T - 2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus.cmd_ready, bus.done, bus.error, tx_trig, bus.wr_data_ready, bus.rd_data_valid} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 100000", {bus.cmd_ready, bus.done, bus.error, tx_trig, bus.wr_data_ready, bus.rd_data_valid});
        end
        checks++;
        if ({tx_data, bus.rd_data} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: got %h exp 0000", {tx_data, bus.rd_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        bq_t exp = '{8'h01, 8'h01, 8'h23, 8'hA5, 8'h5A};
        int d0 = done_cnt;
        tx_log.delete();
        issue(1'b0, 7'h01, 16'h0123, 8'd1);
        fork
            begin feed(8'hA5); feed(8'h5A); end
            wait_done(d0, 20000);
        join
        checks++;
        if (!q_eq(tx_log, exp)) begin
            errors++;
            $display("FAIL write_frame: got %p exp %p", tx_log, exp);
        end
        checks++;
        if (done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL write_done: got %0d pulses exp 1", done_cnt - d0);
        end
        checks++;
        if (done_err !== 1'b0) begin
            errors++;
            $display("FAIL write_err: got %b exp 0", done_err);
        end
        // last trig -> busy clears BYTE_T+1 later -> GAP cycles -> DONE
        checks++;
        if (done_cyc - tx_last_cyc != BYTE_T + 2 + GAP) begin
            errors++;
            $display("FAIL write_gap: got %0d exp %0d", done_cyc - tx_last_cyc, BYTE_T + 2 + GAP);
        end
    endtask

    task automatic test_read();
        bq_t exp  = '{8'h81, 8'h0F, 8'hFF, 8'h03};
        bq_t rexp = '{8'h11, 8'h22, 8'h33, 8'h44};
        int d0 = done_cnt;
        tx_log.delete();
        rd_log.delete();
        issue(1'b1, 7'h01, 16'h0FFF, 8'd3);
        wait_tx(4);
        checks++;
        if (!q_eq(tx_log, exp)) begin
            errors++;
            $display("FAIL read_frame: got %p exp %p", tx_log, exp);
        end
        // echo lands inside the gap, data bytes after it
        while (cyc < tx_last_cyc + 600) @(negedge clk);
        inject(8'h81);
        foreach (rexp[i]) inject(rexp[i]);
        wait_done(d0, 2000);
        checks++;
        if (!q_eq(rd_log, rexp)) begin
            errors++;
            $display("FAIL read_data: got %p exp %p", rd_log, rexp);
        end
        checks++;
        if (done_cnt != d0 + 1 || done_err !== 1'b0) begin
            errors++;
            $display("FAIL read_done: got pulses=%0d err=%b exp pulses=1 err=0", done_cnt - d0, done_err);
        end
        checks++;
        if (done_cyc != last_rx + 1) begin
            errors++;
            $display("FAIL read_done_time: got %0d exp %0d", done_cyc, last_rx + 1);
        end
    endtask

    task automatic test_mismatch();
        int d0 = done_cnt;
        tx_log.delete();
        rd_log.delete();
        issue(1'b1, 7'h01, 16'h0FFF, 8'd3);
        wait_tx(4);
        while (cyc < tx_last_cyc + 800) @(negedge clk);
        inject(8'h82);
        inject(8'h11); inject(8'h22); inject(8'h33); inject(8'h44);
        wait_done(d0, 2000);
        checks++;
        if (rd_log.size() != 0) begin
            errors++;
            $display("FAIL mism_rdvalid: got %0d bytes exp 0", rd_log.size());
        end
        checks++;
        if (done_cnt != d0 + 1 || done_err !== 1'b1) begin
            errors++;
            $display("FAIL mism_done: got pulses=%0d err=%b exp pulses=1 err=1", done_cnt - d0, done_err);
        end
        checks++;
        if (done_cyc != last_rx + 1) begin
            errors++;
            $display("FAIL mism_drain: got done at %0d exp %0d", done_cyc, last_rx + 1);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (bus.error !== 1'b1) begin
            errors++;
            $display("FAIL mism_err_hold: got %b exp 1", bus.error);
        end
    endtask

    task automatic test_timeout();
        bq_t exp = '{8'h81, 8'h00, 8'h10, 8'h00};
        int d0 = done_cnt;
        tx_log.delete();
        issue(1'b1, 7'h01, 16'h0010, 8'd0);
        wait_tx(4);
        wait_done(d0, RESP + GAP + 2000);
        checks++;
        if (!q_eq(tx_log, exp)) begin
            errors++;
            $display("FAIL tmo_frame: got %p exp %p", tx_log, exp);
        end
        checks++;
        if (done_cnt != d0 + 1 || done_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_done: got pulses=%0d err=%b exp pulses=1 err=1", done_cnt - d0, done_err);
        end
        checks++;
        if (done_cyc - tx_last_cyc != BYTE_T + 2 + GAP + RESP) begin
            errors++;
            $display("FAIL tmo_time: got %0d exp %0d", done_cyc - tx_last_cyc, BYTE_T + 2 + GAP + RESP);
        end
    endtask

    task automatic test_stall();
        bq_t exp = '{8'h05, 8'hBE, 8'hEF, 8'h11, 8'h22, 8'h33};
        int d0 = done_cnt;
        int n0 = 0;
        tx_log.delete();
        issue(1'b0, 7'h05, 16'hBEEF, 8'd2);
        checks++;
        if (bus.error !== 1'b0) begin
            errors++;
            $display("FAIL stall_err_clear: got %b exp 0", bus.error);
        end
        fork
            begin
                feed(8'h11);
                #1 n0 = tx_log.size();
                repeat (1000) @(negedge clk);
                #1;
                checks++;
                if (tx_log.size() != n0) begin
                    errors++;
                    $display("FAIL stall_trig: got %0d bytes exp %0d", tx_log.size(), n0);
                end
                feed(8'h22);
                feed(8'h33);
            end
            wait_done(d0, 20000);
        join
        checks++;
        if (!q_eq(tx_log, exp)) begin
            errors++;
            $display("FAIL stall_frame: got %p exp %p", tx_log, exp);
        end
        checks++;
        if (done_cnt != d0 + 1 || done_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: got pulses=%0d err=%b exp pulses=1 err=0", done_cnt - d0, done_err);
        end
    endtask

    task automatic test_abort();
        bq_t exp = '{8'h03, 8'h00, 8'h01, 8'h99};
        int d0 = done_cnt;
        tx_log.delete();
        issue(1'b0, 7'h02, 16'h4455, 8'd0);
        wait_tx(2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.cmd_ready, bus.done, bus.error, tx_trig, bus.wr_data_ready, bus.rd_data_valid} !== 6'b100000) begin
            errors++;
            $display("FAIL abort_flags: got %b exp 100000", {bus.cmd_ready, bus.done, bus.error, tx_trig, bus.wr_data_ready, bus.rd_data_valid});
        end
        checks++;
        if (tx_data !== 8'h00) begin
            errors++;
            $display("FAIL abort_txdata: got %h exp 00", tx_data);
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        tx_log.delete();
        issue(1'b0, 7'h03, 16'h0001, 8'd0);
        fork
            feed(8'h99);
            wait_done(d0, 20000);
        join
        checks++;
        if (!q_eq(tx_log, exp)) begin
            errors++;
            $display("FAIL abort_next_frame: got %p exp %p", tx_log, exp);
        end
        checks++;
        if (done_cnt != d0 + 1 || done_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_next_done: got pulses=%0d err=%b exp pulses=1 err=0", done_cnt - d0, done_err);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL tx_handshake: got %0d violations exp 0", viol);
        end
    endtask

    initial begin
        bus.cmd_valid     = 1'b0;
        bus.cmd_read      = 1'b0;
        bus.cmd_slave_id  = '0;
        bus.cmd_address   = '0;
        bus.cmd_len_m1    = '0;
        bus.wr_data       = '0;
        bus.wr_data_valid = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_timeout();
        test_stall();
        test_abort();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
